// File: rtl/udp_rx_parser.sv
// UDP receive parser: filters Ethernet/IPv4/UDP frames addressed to this node,
// strips the 42-byte header, realigns payload to byte 0 and trims padding.
module udp_rx_parser #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_BYTES  = 42
) (
  input  logic                  rx_axis_aclk,
  input  logic                  rx_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] cmac_rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] cmac_rx_axis_tkeep,
  input  logic                  cmac_rx_axis_tvalid,
  input  logic                  cmac_rx_axis_tlast,
  input  logic [1:0]            cmac_rx_axis_tuser,
  output logic                  cmac_rx_axis_tready,
  output logic [DATA_WIDTH-1:0] udp_rx_axis_tdata,
  output logic [KEEP_WIDTH-1:0] udp_rx_axis_tkeep,
  output logic                  udp_rx_axis_tvalid,
  output logic                  udp_rx_axis_tlast,
  output logic [1:0]            udp_rx_axis_tuser,
  input  logic                  udp_rx_axis_tready,
  input  logic [47:0]           my_config_macAddr,
  input  logic [31:0]           my_config_ipAddr,
  input  logic [15:0]           my_config_udpPort,
  output logic [47:0]           meta_srcMac,
  output logic [31:0]           meta_srcIp,
  output logic [15:0]           meta_srcPort,
  output logic [15:0]           meta_payloadLen,
  output logic [31:0]           stat_rx_pkts,
  output logic [31:0]           stat_rx_drops
);
  localparam int CARRY_BYTES = KEEP_WIDTH - HDR_BYTES;
  localparam int CARRY_BITS  = CARRY_BYTES * 8;
  localparam int HDR_BITS    = HDR_BYTES * 8;

  typedef enum logic [1:0] {IDLE, PASS, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;

  logic [CARRY_BITS-1:0] carry_q, carry_d;
  logic [15:0]           rem_q, rem_d;
  logic [6:0]            flush_cnt_q, flush_cnt_d;
  logic                  flush_err_q, flush_err_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d, out_load;
  logic [1:0]            out_user_q, out_user_d;
  logic [47:0]           smac_q, smac_d;
  logic [31:0]           sip_q, sip_d, pkts_q, pkts_d, drops_q, drops_d;
  logic [15:0]           sport_q, sport_d, plen_q, plen_d;

  logic [7:0]  hb [HDR_BYTES];
  logic [47:0] h_dmac, h_smac;
  logic [31:0] h_sip, h_dip;
  logic [15:0] h_etype, h_frag, h_sport, h_dport, h_ulen, h_plen;
  logic [6:0]  in_cnt, avail, nbytes;
  logic        hdr_ok, out_ready, in_ready, in_fire;

  function automatic logic [6:0] min_len(input logic [6:0] a, input logic [15:0] rem);
    return (rem < 16'(a)) ? rem[6:0] : a;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [6:0] n);
    logic [KEEP_WIDTH-1:0] m;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) m[i] = (i < 32'(n));
    return m;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < HDR_BYTES; i++) hb[i] = cmac_rx_axis_tdata[8*i +: 8];
    in_cnt = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) in_cnt = in_cnt + 7'(cmac_rx_axis_tkeep[i]);
  end

  assign h_dmac  = {hb[0], hb[1], hb[2], hb[3], hb[4], hb[5]};
  assign h_smac  = {hb[6], hb[7], hb[8], hb[9], hb[10], hb[11]};
  assign h_etype = {hb[12], hb[13]};
  assign h_frag  = {hb[20], hb[21]};
  assign h_sip   = {hb[26], hb[27], hb[28], hb[29]};
  assign h_dip   = {hb[30], hb[31], hb[32], hb[33]};
  assign h_sport = {hb[34], hb[35]};
  assign h_dport = {hb[36], hb[37]};
  assign h_ulen  = {hb[38], hb[39]};
  assign h_plen  = h_ulen - 16'd8;

  // DF (bit 14) is deliberately ignored; only MF and the offset reject.
  assign hdr_ok = ((h_dmac == my_config_macAddr) || (h_dmac == '1)) &&
                  (h_etype == 16'h0800) && (hb[14] == 8'h45) &&
                  !h_frag[13] && (h_frag[12:0] == '0) && (hb[23] == 8'd17) &&
                  (h_dip == my_config_ipAddr) && (h_dport == my_config_udpPort) &&
                  (h_ulen >= 16'd9) && (in_cnt >= 7'(HDR_BYTES));

  assign out_ready = !out_valid_q || udp_rx_axis_tready;
  assign in_ready  = (state_q == DRAIN) || ((state_q != FLUSH) && out_ready);
  assign in_fire   = cmac_rx_axis_tvalid && in_ready;

  always_comb begin
    state_d = state_q;      carry_d = carry_q;         rem_d = rem_q;
    flush_cnt_d = flush_cnt_q;  flush_err_d = flush_err_q;
    smac_d = smac_q;  sip_d = sip_q;  sport_d = sport_q;  plen_d = plen_q;
    pkts_d = pkts_q;  drops_d = drops_q;
    out_load = 1'b0;  out_data_d = out_data_q;  out_keep_d = out_keep_q;
    out_last_d = out_last_q;  out_user_d = out_user_q;
    avail = '0;  nbytes = '0;
    unique case (state_q)
      IDLE: if (in_fire) begin
        if (hdr_ok) begin
          smac_d = h_smac;  sip_d = h_sip;  sport_d = h_sport;  plen_d = h_plen;
          pkts_d = sat_inc(pkts_q);
          rem_d = h_plen;
          carry_d = cmac_rx_axis_tdata[DATA_WIDTH-1 -: CARRY_BITS];
          if (cmac_rx_axis_tlast) begin
            avail = in_cnt - 7'(HDR_BYTES);
            nbytes = min_len(avail, h_plen);
            rem_d = h_plen - 16'(nbytes);
            out_load = 1'b1;
            out_data_d = {{HDR_BITS{1'b0}}, cmac_rx_axis_tdata[DATA_WIDTH-1 -: CARRY_BITS]};
            out_keep_d = keep_mask(nbytes);
            out_last_d = 1'b1;
            out_user_d = {rem_d != '0, cmac_rx_axis_tuser[0]};
          end else begin
            state_d = PASS;
          end
        end else begin
          drops_d = sat_inc(drops_q);
          if (!cmac_rx_axis_tlast) state_d = DRAIN;
        end
      end
      PASS: if (in_fire) begin
        // Carried bytes fill output 0..21, current bytes 0..41 fill 22..63.
        if (cmac_rx_axis_tlast)
          avail = 7'(CARRY_BYTES) + ((in_cnt > 7'(HDR_BYTES)) ? 7'(HDR_BYTES) : in_cnt);
        else
          avail = 7'(KEEP_WIDTH);
        nbytes = min_len(avail, rem_q);
        rem_d = rem_q - 16'(nbytes);
        carry_d = cmac_rx_axis_tdata[DATA_WIDTH-1 -: CARRY_BITS];
        out_load = 1'b1;
        out_data_d = {cmac_rx_axis_tdata[HDR_BITS-1:0], carry_q};
        out_keep_d = keep_mask(nbytes);
        out_last_d = 1'b0;
        out_user_d = '0;
        if (rem_d == '0) begin
          out_last_d = 1'b1;
          out_user_d = {1'b0, cmac_rx_axis_tlast & cmac_rx_axis_tuser[0]};
          state_d = cmac_rx_axis_tlast ? IDLE : DRAIN;
        end else if (cmac_rx_axis_tlast) begin
          if (in_cnt > 7'(HDR_BYTES)) begin
            flush_cnt_d = in_cnt - 7'(HDR_BYTES);
            flush_err_d = cmac_rx_axis_tuser[0];
            state_d = FLUSH;
          end else begin
            out_last_d = 1'b1;
            out_user_d = {1'b1, cmac_rx_axis_tuser[0]};
            state_d = IDLE;
          end
        end
      end
      FLUSH: if (out_ready) begin
        nbytes = min_len(flush_cnt_q, rem_q);
        rem_d = rem_q - 16'(nbytes);
        out_load = 1'b1;
        out_data_d = {{HDR_BITS{1'b0}}, carry_q};
        out_keep_d = keep_mask(nbytes);
        out_last_d = 1'b1;
        out_user_d = {rem_d != '0, flush_err_q};
        state_d = IDLE;
      end
      DRAIN: if (in_fire && cmac_rx_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = out_load || (out_valid_q && !udp_rx_axis_tready);
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state_q <= IDLE;  carry_q <= '0;  rem_q <= '0;
      flush_cnt_q <= '0;  flush_err_q <= 1'b0;
      out_valid_q <= 1'b0;  out_data_q <= '0;  out_keep_q <= '0;
      out_last_q <= 1'b0;  out_user_q <= '0;
      smac_q <= '0;  sip_q <= '0;  sport_q <= '0;  plen_q <= '0;
      pkts_q <= '0;  drops_q <= '0;
    end else begin
      state_q <= state_d;  carry_q <= carry_d;  rem_q <= rem_d;
      flush_cnt_q <= flush_cnt_d;  flush_err_q <= flush_err_d;
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;  out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;  out_user_q <= out_user_d;
      smac_q <= smac_d;  sip_q <= sip_d;  sport_q <= sport_d;  plen_q <= plen_d;
      pkts_q <= pkts_d;  drops_q <= drops_d;
    end
  end

  assign cmac_rx_axis_tready = in_ready;
  assign udp_rx_axis_tdata   = out_data_q;
  assign udp_rx_axis_tkeep   = out_keep_q;
  assign udp_rx_axis_tvalid  = out_valid_q;
  assign udp_rx_axis_tlast   = out_last_q;
  assign udp_rx_axis_tuser   = out_user_q;
  assign meta_srcMac         = smac_q;
  assign meta_srcIp          = sip_q;
  assign meta_srcPort        = sport_q;
  assign meta_payloadLen     = plen_q;
  assign stat_rx_pkts        = pkts_q;
  assign stat_rx_drops       = drops_q;
endmodule
